// File: rtl/instr_mem_loadable_if.sv
// instr_mem_loadable_if: read and load port bundle for instr_mem_loadable
//   read : rd_en, rd_addr -> rd_data, rd_valid, par_err
//   load : ld_start, ld_data, ld_valid, ld_last -> ld_ready, ld_done, busy
//   master drives requests (core / boot loader), slave is the memory
interface instr_mem_loadable_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              ld_start;
    logic [DATA_W-1:0] ld_data;
    logic              ld_valid;
    logic              ld_last;
    logic              ld_ready;
    logic              ld_done;
    logic              busy;
    logic              par_err;
    modport master (
        output rd_en, rd_addr, ld_start, ld_data, ld_valid, ld_last,
        input  rd_data, rd_valid, ld_ready, ld_done, busy, par_err
    );
    modport slave (
        input  rd_en, rd_addr, ld_start, ld_data, ld_valid, ld_last,
        output rd_data, rd_valid, ld_ready, ld_done, busy, par_err
    );
endinterface

// File: rtl/instr_mem_loadable.sv
// instr_mem_loadable: loadable LEGv8 instruction memory, registered read port plus streaming load port
//   clock, reset : rising-edge clock, synchronous active-high reset
//   bus (slave)  : read port (rd_en/rd_addr -> rd_data/rd_valid/par_err, 1-cycle latency)
//                  load port (ld_start/ld_data/ld_valid/ld_last -> ld_ready/ld_done/busy)
//   IMEM_PARITY_EN : when defined, keeps an even-parity bit per word and flags mismatches on read
// Unwritten, padded and out-of-range words read as DEFAULT_WORD (BR XZR), so the core restarts at 0.
module instr_mem_loadable #(
    parameter int                ADDR_W       = 16,
    parameter int                DATA_W       = 32,
    parameter int                DEPTH        = 256,
    parameter logic [DATA_W-1:0] DEFAULT_WORD = DATA_W'(32'hD60003E0)
) (
    input logic                 clock,
    input logic                 reset,
    instr_mem_loadable_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic [1:0] {RUN, LOAD, FILL} state_t;
    state_t            state, state_n;
    logic [CW-1:0]     cnt;
    logic              full, last_word, we, rd_acc, rd_in;
    logic [DATA_W-1:0] wdata;
    logic [AW-1:0]     ra;
    // Power-up image: every word is the restart branch; reset never clears it.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: DEFAULT_WORD};
    assign full      = cnt == CW'(DEPTH);
    assign last_word = bus.ld_valid && (bus.ld_last || cnt == CW'(DEPTH - 1));
    assign ra        = bus.rd_addr[AW-1:0];
    always_ff @(posedge clock)
        if (reset) state <= RUN;
        else       state <= state_n;
    always_comb begin
        state_n = state == RUN  && bus.ld_start ? LOAD :
                  state == LOAD && last_word    ? FILL :
                  state == FILL && full         ? RUN  : state;
    end
    always_comb begin
        bus.ld_ready = state == LOAD;
        bus.busy     = state != RUN;
        bus.ld_done  = state == FILL && full;
    end
    // Writes are gated by reset so an aborted load leaves the word in flight untouched.
    always_comb begin
        we     = !reset && ((state == LOAD && bus.ld_valid) || (state == FILL && !full));
        wdata  = state == LOAD ? bus.ld_data : DEFAULT_WORD;
        rd_acc = state == RUN && !bus.ld_start && bus.rd_en;
        rd_in  = {1'b0, bus.rd_addr} < (ADDR_W + 1)'(DEPTH);
    end
    always_ff @(posedge clock)
        if (we) mem[cnt[AW-1:0]] <= wdata;
    always_ff @(posedge clock)
        if (reset) begin
            cnt          <= '0;
            bus.rd_data  <= DEFAULT_WORD;
            bus.rd_valid <= 1'b0;
        end else begin
            cnt          <= state == RUN && bus.ld_start ? '0 : we ? cnt + 1'b1 : cnt;
            bus.rd_valid <= rd_acc;
            if (rd_acc) bus.rd_data <= rd_in ? mem[ra] : DEFAULT_WORD;
        end
`ifdef IMEM_PARITY_EN
    logic par [DEPTH] = '{default: ^DEFAULT_WORD};
    always_ff @(posedge clock)
        if (we) par[cnt[AW-1:0]] <= ^wdata;
    // Out-of-range reads return the constant default word, which can never mismatch.
    always_ff @(posedge clock)
        if (reset) bus.par_err <= 1'b0;
        else       bus.par_err <= rd_acc && rd_in && ((^mem[ra]) != par[ra]);
`else
    assign bus.par_err = 1'b0;
`endif
endmodule

// File: doc/instr_mem_loadable.md
# instr_mem_loadable

Parametrised, synchronous instruction memory for the LEGv8 core, replacing the fixed combinational case-ROM. It has a registered read port with a valid flag and a streaming load port. The load port lets a test harness or boot loader rewrite the program at run time without resynthesis. Unwritten and out-of-range locations return the default word `BR XZR` (0xD60003E0), so the core restarts at address 0 when it runs off the end of the program.

## Interface

Parameters:
- ADDR_W, 16, read address width (word address, matches PC word index)
- DATA_W, 32, instruction width
- DEPTH, 256, number of stored words; must satisfy 2 ≤ DEPTH ≤ 2^ADDR_W
- DEFAULT_WORD, 32'hD60003E0, returned for unwritten, padded or out-of-range words

Ports:
- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- rd_en  in  1  read request, sampled each cycle
- rd_addr  in  ADDR_W  word address to read
- rd_data  out  DATA_W  registered instruction
- rd_valid  out  1  rd_data holds the result of the previous cycle's accepted read
- ld_start  in  1  begin a program load (honoured only in RUN)
- ld_data  in  DATA_W  instruction word to load
- ld_valid  in  1  ld_data valid
- ld_last  in  1  qualifies ld_data as the final program word
- ld_ready  out  1  load port can accept a word this cycle
- ld_done  out  1  one-cycle pulse when the load and padding complete
- busy  out  1  high in LOAD or FILL
- par_err  out  1  parity mismatch on the current rd_data (see Configuration)

## Operation

- States: RUN, LOAD, FILL. Reset enters RUN.
- RUN:
  - A read is accepted when rd_en=1.
  - ld_start=1 moves the block to LOAD, clears the word counter cnt (width clog2(DEPTH)+1) and ignores rd_en that cycle.
- LOAD:
  - ld_ready=1.
  - Each cycle with ld_valid && ld_ready writes ld_data to mem[cnt] and increments cnt.
  - If the transfer has ld_last=1, or cnt reaches DEPTH-1, the block goes to FILL; in the cnt=DEPTH-1 case the write is the final word.
  - ld_start is ignored while not in RUN.
- FILL:
  - ld_ready=0.
  - Writes DEFAULT_WORD to mem[cnt] and increments cnt, one word per cycle, until cnt==DEPTH.
  - Then ld_done pulses for one cycle and the state returns to RUN.
  - If the load filled the whole memory, FILL lasts exactly one cycle, writes nothing and pulses ld_done.
- Reads:
  - Reads are not accepted in LOAD or FILL. rd_valid=0 there and rd_en is ignored. The core must stall while busy=1.
  - rd_addr ≥ DEPTH returns DEFAULT_WORD. Upper address bits are not aliased.
- Memory power-up contents: every word is DEFAULT_WORD (initialised array). Reset does not clear the memory.
- Reset mid-load: the block returns to RUN. Words already written are kept; the remaining words keep their previous contents. ld_done is not pulsed.

## Timing

- Read latency is 1 cycle. rd_en at edge N gives rd_data and rd_valid=1 after edge N+1.
- rd_valid deasserts the cycle after rd_en=0. rd_data holds its last value when no read is accepted.
- Read-during-write is not possible, because reads are blocked while writes occur.
- Load throughput is 1 word per cycle. Total load time for k words is k + (DEPTH-k) + 1 cycles, where the +1 is the ld_done cycle.
- busy is high from the cycle after ld_start through the cycle ld_done is asserted, inclusive.
- Reset values: rd_data=DEFAULT_WORD, rd_valid=0, ld_ready=0, ld_done=0, busy=0, par_err=0, cnt=0.

## Configuration

- IMEM_PARITY_EN:
  - When defined, each word is stored with an extra even-parity bit computed on write, including padding words.
  - Each read recomputes the parity. par_err=1 in the same cycle as rd_valid on a mismatch; otherwise par_err=0.
  - When undefined, there is no parity storage and par_err is tied to 0.

## Test plan

- Reset, then read addresses 0, 5 and DEPTH+3 → rd_data=0xD60003E0 each time, with rd_valid one cycle after each rd_en.
- Load 3 words (0xD2800021, 0xD2800042, 0x8B020024 with ld_last) → busy=1, FILL pads to DEPTH, ld_done pulses once. Reading 0, 1, 2, 3 then returns the three words followed by 0xD60003E0.
- Load with ld_valid toggling every other cycle → ld_ready=1 throughout LOAD, exactly the valid words are stored in order, no gaps.
- Load DEPTH words without ld_last → the load auto-terminates, FILL lasts 1 cycle, and mem[DEPTH-1] equals the last word sent.
- Assert reset after 2 of 4 words → state RUN, ld_done=0, and words 0–1 read back as new data while 2–3 read back as old data.
- With IMEM_PARITY_EN, force a stored bit flip via backdoor → par_err=1 with rd_valid on that read only; without the macro, par_err stays 0.
